// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: act-reader FSM encoding, direction flags and
// activation-SRAM base addresses shared with the LSTM sequencer.
package lstm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } act_rd_state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  localparam int unsigned LSTM_HS = 32;
  localparam int unsigned LSTM_T  = 64;

  localparam int unsigned ACT_ADDR_FWD_INIT = 0;
  localparam int unsigned ACT_ADDR_BWD_INIT = LSTM_T * LSTM_HS;

  // Counter width for a 0..n-1 range; a single-value range still gets one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lstm_act_fifo2.sv
// Two-entry FIFO buffering act-SRAM return data plus tag bits.
module lstm_act_fifo2 #(
  parameter int unsigned W = 10
) (
  input  logic         wclk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign dout    = mem[rd_ptr];
  assign empty   = (count == 2'd0);

  always_ff @(posedge wclk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lstm_act_reader.sv
// Streams final-layer forward/backward hidden states out of the activation
// SRAM as a valid/ready byte stream, HS fwd then HS bwd bytes per timestep.
module lstm_act_reader
  import lstm_pkg::*;
#(
  parameter int unsigned DATA_DW       = 8,
  parameter int unsigned SRAM8192_AW   = 13,
  parameter int unsigned HS            = LSTM_HS,
  parameter int unsigned T             = LSTM_T,
  parameter int unsigned ADDR_FWD_INIT = ACT_ADDR_FWD_INIT,
  parameter int unsigned ADDR_BWD_INIT = T * HS
) (
  input  logic                      wclk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DATA_DW-1:0]        sram_act_dout,
  output logic [SRAM8192_AW-1:0]    addr_sram_act,
  output logic                      sram_act_en,
  output logic                      sram_act_we,
  output logic signed [DATA_DW-1:0] out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      out_last_t,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IW = cnt_w(HS);
  localparam int unsigned TW = cnt_w(T);
  localparam int unsigned FW = DATA_DW + 2;

  act_rd_state_t state_q, state_d;

  logic [IW-1:0]          i_q;
  logic                   dir_q;
  logic [TW-1:0]          t_q;
  logic                   inflight_q;
  logic                   last_t_q;
  logic                   last_q;
  logic [SRAM8192_AW-1:0] addr_q;
  logic [SRAM8192_AW-1:0] addr_now;

  logic [1:0]    fifo_count;
  logic          fifo_empty;
  logic [FW-1:0] fifo_dout;

  logic       pop;
  logic       issue;
  logic       credit_ok;
  logic [2:0] occ;
  logic       i_end;
  logic       t_end;
  logic       last_addr;
  logic       tag_last_t;
  logic       tag_last;

  assign pop = !fifo_empty && out_rdy;

  // A slot freed by this cycle's pop is reusable immediately; otherwise the
  // 1-cycle SRAM latency would halve throughput with out_rdy held high.
  assign occ       = 3'(fifo_count) + 3'(inflight_q);
  assign credit_ok = (occ < (3'd2 + 3'(pop)));

  assign i_end      = (i_q == IW'(HS - 1));
  assign t_end      = (t_q == TW'(T - 1));
  assign tag_last_t = i_end && (dir_q == DIR_BWD);
  assign tag_last   = tag_last_t && t_end;
  assign last_addr  = tag_last;

  assign addr_now = ((dir_q == DIR_BWD) ? SRAM8192_AW'(ADDR_BWD_INIT) : SRAM8192_AW'(ADDR_FWD_INIT))
                  + SRAM8192_AW'(t_q) * SRAM8192_AW'(HS)
                  + SRAM8192_AW'(i_q);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_READ;
      end
      ST_READ: begin
        busy  = 1'b1;
        issue = credit_ok;
        if (issue && last_addr) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave once the FIFO empties this cycle, so done follows the last byte directly.
        if (!inflight_q && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop)))
          state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sram_act_en   = issue;
  assign sram_act_we   = 1'b0;
  assign addr_sram_act = issue ? addr_now : addr_q;

  always_ff @(posedge wclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      dir_q      <= DIR_FWD;
      t_q        <= '0;
      inflight_q <= 1'b0;
      last_t_q   <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if ((state_q == ST_IDLE) && start) begin
        i_q   <= '0;
        dir_q <= DIR_FWD;
        t_q   <= '0;
      end else if (issue) begin
        addr_q   <= addr_now;
        last_t_q <= tag_last_t;
        last_q   <= tag_last;
        if (i_end) begin
          i_q <= '0;
          if (dir_q == DIR_BWD) begin
            dir_q <= DIR_FWD;
            t_q   <= t_end ? '0 : t_q + TW'(1);
          end else begin
            dir_q <= DIR_BWD;
          end
        end else begin
          i_q <= i_q + IW'(1);
        end
      end
    end
  end

  lstm_act_fifo2 #(
    .W (FW)
  ) u_fifo (
    .wclk  (wclk),
    .rst   (rst),
    .push  (inflight_q),
    .din   ({sram_act_dout, last_t_q, last_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign out_vld    = !fifo_empty;
  assign out_data   = fifo_dout[FW-1:2];
  assign out_last_t = fifo_dout[1] && !fifo_empty;
  assign out_last   = fifo_dout[0] && !fifo_empty;

endmodule

// File: tb/tb_lstm_act_reader.sv
// Bench for lstm_act_reader: a small HS=4/T=2 instance for exact sequencing
// and a default-size instance driven with random backpressure.
module tb_lstm_act_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              s_start, s_en, s_we, s_vld, s_rdy, s_lt, s_l, s_busy, s_done;
  logic [7:0]        s_dout;
  logic [12:0]       s_addr;
  logic signed [7:0] s_data;

  logic              b_start, b_en, b_we, b_vld, b_rdy, b_lt, b_l, b_busy, b_done;
  logic [7:0]        b_dout;
  logic [12:0]       b_addr;
  logic signed [7:0] b_data;

  int checks = 0;
  int errors = 0;

  lstm_act_reader #(.HS(4), .T(2)) dut_s (
    .wclk(clk), .rst(rst), .start(s_start), .sram_act_dout(s_dout),
    .addr_sram_act(s_addr), .sram_act_en(s_en), .sram_act_we(s_we),
    .out_data(s_data), .out_vld(s_vld), .out_rdy(s_rdy),
    .out_last_t(s_lt), .out_last(s_l), .busy(s_busy), .done(s_done)
  );

  lstm_act_reader dut_b (
    .wclk(clk), .rst(rst), .start(b_start), .sram_act_dout(b_dout),
    .addr_sram_act(b_addr), .sram_act_en(b_en), .sram_act_we(b_we),
    .out_data(b_data), .out_vld(b_vld), .out_rdy(b_rdy),
    .out_last_t(b_lt), .out_last(b_l), .busy(b_busy), .done(b_done)
  );

  // Act SRAM models: 1-cycle read latency, mem[a] = a[7:0]
  always @(posedge clk) if (s_en) s_dout <= s_addr[7:0];
  always @(posedge clk) if (b_en) b_dout <= b_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b_outs();
    return {4'b0, b_en, b_we, b_vld, b_lt, b_l, b_busy, b_done, b_data, b_addr};
  endfunction

  function automatic logic [31:0] s_outs();
    return {4'b0, s_en, s_we, s_vld, s_lt, s_l, s_busy, s_done, s_data, s_addr};
  endfunction

  // One pass on the default-size instance, checked against a model built
  // from the addressing rule.
  task automatic run_big(input int rdy_pct, input int hold, input int restart_at, input int abort_at);
    int exp_a[$];
    int exp_w[$];
    int n_iss, n_xfer, n_done, cyc, max_out;
    logic aborted, pv, prdy;
    logic [9:0] pword, word;
    n_iss = 0; n_xfer = 0; n_done = 0; cyc = 0; max_out = 0;
    aborted = 1'b0; pv = 1'b0; prdy = 1'b0; pword = '0;
    for (int t = 0; t < 64; t++)
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 32; i++) begin
          int a;
          a = (d == 1 ? 64 * 32 : 0) + t * 32 + i;
          exp_a.push_back(a);
          exp_w.push_back(int'({a[7:0], (d == 1 && i == 31), (d == 1 && i == 31 && t == 63)}));
        end
    b_start = 1'b1;
    step();
    while (n_done == 0 && cyc < 20000) begin
      cyc++;
      b_rdy   = (cyc <= hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      b_start = (cyc == restart_at);
      #1;
      word = {b_data, b_lt, b_l};
      if (b_en) begin
        if (n_iss < exp_a.size()) chk("b_addr", 32'(b_addr), exp_a[n_iss]);
        n_iss++;
      end
      if (pv && !prdy) chk("b_hold", {b_vld, word}, {1'b1, pword});
      if (b_vld && b_rdy) begin
        if (n_xfer < exp_w.size()) chk("b_word", 32'(word), exp_w[n_xfer]);
        n_xfer++;
      end
      if (n_iss - n_xfer > max_out) max_out = n_iss - n_xfer;
      if (b_done) n_done++;
      if (hold > 0 && cyc == hold) begin
        chk("hold_issues", n_iss, 2);
        chk("hold_en_low", b_en, 0);
      end
      pv = b_vld; prdy = b_rdy; pword = word;
      if (abort_at > 0 && n_xfer == abort_at) begin
        rst = 1'b1;
        step();
        chk("abort_outs", b_outs(), 0);
        chk("abort_no_done", n_done, 0);
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      step();
    end
    if (!aborted) begin
      b_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (b_done) n_done++;
        step();
      end
      chk("b_xfers", n_xfer, 4096);
      chk("b_issues", n_iss, 4096);
      chk("b_done_pulses", n_done, 1);
      chk("b_outstanding_le2", (max_out <= 2), 1);
      chk("b_idle_after", {b_busy, b_vld, b_en}, 0);
    end
  endtask

  logic [7:0] s_exp [16];
  int n, first_c, last_c, done_c, nd;

  initial begin
    s_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd8, 8'd9, 8'd10, 8'd11,
              8'd4, 8'd5, 8'd6, 8'd7, 8'd12, 8'd13, 8'd14, 8'd15};
    n = 0; first_c = -1; last_c = -1; done_c = -1; nd = 0;
    rst = 1'b1; s_start = 1'b0; b_start = 1'b0; s_rdy = 1'b0; b_rdy = 1'b0;
    repeat (3) step();
    chk("rst_b", b_outs(), 0);
    chk("rst_s", s_outs(), 0);
    rst = 1'b0;
    step();

    // Small pass, out_rdy held high
    s_rdy = 1'b1; s_start = 1'b1;
    step();
    s_start = 1'b0;
    chk("s_en_c1", s_en, 1);
    chk("s_busy_c1", s_busy, 1);
    for (int c = 1; c < 60; c++) begin
      if (c == 2) chk("s_vld_c2", s_vld, 0);
      if (c == 3) chk("s_vld_c3", s_vld, 1);
      if (s_vld && s_rdy) begin
        if (n < 16) chk("s_word", {s_data, s_lt, s_l}, {s_exp[n], (n == 7 || n == 15), (n == 15)});
        if (n == 0) first_c = c;
        last_c = c;
        n++;
      end
      if (s_done) begin
        nd++;
        done_c = c;
      end
      step();
    end
    chk("s_count", n, 16);
    chk("s_consecutive", last_c - first_c, 15);
    chk("s_done_cycle", done_c, last_c + 1);
    chk("s_done_pulses", nd, 1);

    run_big(50, 0, -1, 0);    // random backpressure
    run_big(100, 20, -1, 0);  // stalled for 20 cycles after start
    run_big(100, 0, 10, 0);   // start again mid-pass
    run_big(60, 0, -1, 100);  // reset at the 100th transfer
    run_big(100, 0, -1, 0);   // clean pass after the abort

    // start and rst together
    rst = 1'b1; b_start = 1'b1; s_start = 1'b1;
    step();
    rst = 1'b0; b_start = 1'b0; s_start = 1'b0;
    chk("rst_start_b", {b_busy, b_en, b_vld}, 0);
    chk("rst_start_s", {s_busy, s_en, s_vld}, 0);
    repeat (3) step();
    chk("rst_start_b_later", {b_busy, b_en, b_vld, b_done}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
